// File: rtl/cv32e40p_alu_mul_serial.sv
// Purpose: radix-2 serial shift-add multiplier for MUL/MULH/MULHSU/MULHU, ECC-protected state.
// Latency: request accepted in cycle 0, result valid in cycle C_WIDTH+1.
// Backpressure: holds FINISH with a stable result until OutRdy_SI; new requests are taken only in IDLE.

// SECDED Hamming-protected register, written every cycle; corrects single-bit faults on read.
module cv32e40p_reg_ecc #(
    parameter int DW = 32
) (
    input  logic          Clk_CI,
    input  logic          rst_n,
    input  logic [DW-1:0] D_DI,
    output logic [DW-1:0] Q_DO,
    output logic          CorrErr_SO,
    output logic          Uncorr_SO
);
    function automatic int parBits(input int dw);
        int r;
        r = 1;
        for (int p = 15; p >= 1; p--) begin
            if ((1 << p) >= dw + p + 1) r = p;
        end
        return r;
    endfunction

    localparam int PW = parBits(DW);
    localparam int NW = DW + PW;

    // Bit 0 holds overall parity; bits 1..NW are Hamming positions (powers of two are check bits).
    function automatic logic [NW:0] encode(input logic [DW-1:0] d);
        logic [NW:0] c;
        logic        par;
        c = '0;
        for (int pos = 3; pos <= NW; pos++) begin
            if ((pos & (pos - 1)) != 0) c[pos] = d[pos - $clog2(pos + 1) - 1];
        end
        for (int i = 0; i < PW; i++) begin
            par = 1'b0;
            for (int pos = 1; pos <= NW; pos++) begin
                if ((pos & (1 << i)) != 0) par = par ^ c[pos];
            end
            c[1 << i] = par;
        end
        c[0] = ^c[NW:1];
        return c;
    endfunction

    logic [NW:0] Data_DP;
    logic [NW:0] fixedCw;
    int          syn;
    logic        ovr;
    logic        par;

    // Storage: encoded on the way in, zero codeword encodes zero data
    always_ff @(posedge Clk_CI or negedge rst_n) begin
        if (!rst_n) Data_DP <= '0;
        else        Data_DP <= encode(D_DI);
    end

    // Syndrome decode, single-bit correction and data extraction
    always_comb begin
        syn     = 0;
        par     = 1'b0;
        ovr     = ^Data_DP;
        fixedCw = Data_DP;
        Q_DO    = '0;
        for (int i = 0; i < PW; i++) begin
            par = 1'b0;
            for (int pos = 1; pos <= NW; pos++) begin
                if ((pos & (1 << i)) != 0) par = par ^ Data_DP[pos];
            end
            if (par) syn = syn | (1 << i);
        end
        if (ovr) begin
            for (int pos = 1; pos <= NW; pos++) begin
                if (syn == pos) fixedCw[pos] = ~fixedCw[pos];
            end
        end
        for (int pos = 3; pos <= NW; pos++) begin
            if ((pos & (pos - 1)) != 0) Q_DO[pos - $clog2(pos + 1) - 1] = fixedCw[pos];
        end
    end

    assign CorrErr_SO = ovr && (syn <= NW);
    assign Uncorr_SO  = (!ovr && (syn != 0)) || (ovr && (syn > NW));
endmodule

module cv32e40p_alu_mul_serial #(
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6
) (
    input  logic               Clk_CI,
    input  logic               Rst_RI,
    input  logic [C_WIDTH-1:0] OpA_DI,
    input  logic [C_WIDTH-1:0] OpB_DI,
    input  logic               OpASign_SI,
    input  logic               OpBSign_SI,
    input  logic               OpHigh_SI,
    input  logic               InVld_SI,
    input  logic               OutRdy_SI,
    output logic               OutVld_SO,
    output logic [C_WIDTH-1:0] Res_DO,
    output logic [4:0]         mem_err_o
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] MULT   = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    logic                   rstN;
    logic [1:0]             State_DP, State_DN;
    logic [C_WIDTH-1:0]     MReg_DP, MReg_DN;
    logic [C_WIDTH-1:0]     ProdHi_DP, ProdHi_DN;
    logic [C_WIDTH-1:0]     ProdLo_DP, ProdLo_DN;
    logic [C_LOG_WIDTH-1:0] Cnt_DP, Cnt_DN;
    logic                   HiSel_SP, ResInv_SP;
    logic [4:0]             corrErr, uncorrErr;
    logic                   isIdle, isFinish, load;
    logic [C_WIDTH-1:0]     magA, magB;
    logic [C_WIDTH:0]       sum;
    logic [2*C_WIDTH-1:0]   prodRaw, prodFinal;

    assign rstN = ~Rst_RI;

    cv32e40p_reg_ecc #(.DW(2)) uState (
        .Clk_CI(Clk_CI), .rst_n(rstN), .D_DI(State_DN), .Q_DO(State_DP),
        .CorrErr_SO(corrErr[0]), .Uncorr_SO(uncorrErr[0]));
    cv32e40p_reg_ecc #(.DW(C_WIDTH)) uMReg (
        .Clk_CI(Clk_CI), .rst_n(rstN), .D_DI(MReg_DN), .Q_DO(MReg_DP),
        .CorrErr_SO(corrErr[1]), .Uncorr_SO(uncorrErr[1]));
    cv32e40p_reg_ecc #(.DW(C_WIDTH)) uProdHi (
        .Clk_CI(Clk_CI), .rst_n(rstN), .D_DI(ProdHi_DN), .Q_DO(ProdHi_DP),
        .CorrErr_SO(corrErr[2]), .Uncorr_SO(uncorrErr[2]));
    cv32e40p_reg_ecc #(.DW(C_WIDTH)) uProdLo (
        .Clk_CI(Clk_CI), .rst_n(rstN), .D_DI(ProdLo_DN), .Q_DO(ProdLo_DP),
        .CorrErr_SO(corrErr[3]), .Uncorr_SO(uncorrErr[3]));
    cv32e40p_reg_ecc #(.DW(C_LOG_WIDTH)) uCnt (
        .Clk_CI(Clk_CI), .rst_n(rstN), .D_DI(Cnt_DN), .Q_DO(Cnt_DP),
        .CorrErr_SO(corrErr[4]), .Uncorr_SO(uncorrErr[4]));

    assign mem_err_o = corrErr | uncorrErr;

    // An uncorrectable state word is treated as neither IDLE nor FINISH so nothing is issued or returned
    assign isIdle    = (State_DP == IDLE)   && !uncorrErr[0];
    assign isFinish  = (State_DP == FINISH) && !uncorrErr[0];
    assign load      = isIdle && InVld_SI;
    assign OutVld_SO = (isIdle && !InVld_SI) || isFinish;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign magA = OpASign_SI ? -OpA_DI : OpA_DI;
    assign magB = OpBSign_SI ? -OpB_DI : OpB_DI;

    // Next-state and datapath: load operands, one shift-add per MULT cycle, hold in FINISH
    always_comb begin
        State_DN  = State_DP;
        MReg_DN   = MReg_DP;
        ProdHi_DN = ProdHi_DP;
        ProdLo_DN = ProdLo_DP;
        Cnt_DN    = Cnt_DP;
        sum       = {1'b0, ProdHi_DP} + (ProdLo_DP[0] ? {1'b0, MReg_DP} : '0);
        case (State_DP)
            IDLE: begin
                if (InVld_SI) begin
                    MReg_DN   = magA;
                    ProdLo_DN = magB;
                    ProdHi_DN = '0;
                    Cnt_DN    = C_LOG_WIDTH'(C_WIDTH - 1);
                    State_DN  = MULT;
                end
            end
            MULT: begin
                ProdHi_DN = sum[C_WIDTH:1];
                ProdLo_DN = {sum[0], ProdLo_DP[C_WIDTH-1:1]};
                if (Cnt_DP == '0) State_DN = FINISH;
                else              Cnt_DN   = Cnt_DP - C_LOG_WIDTH'(1);
            end
            FINISH: begin
                if (OutRdy_SI) State_DN = IDLE;
            end
            default: State_DN = IDLE;
        endcase
        if (uncorrErr[0]) State_DN = IDLE;
    end

    // Result selection flags captured at issue time
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            HiSel_SP  <= 1'b0;
            ResInv_SP <= 1'b0;
        end else if (load) begin
            HiSel_SP  <= OpHigh_SI;
            ResInv_SP <= OpASign_SI ^ OpBSign_SI;
        end
    end

    // Sign correction over the full double-width product, then word select
    assign prodRaw   = {ProdHi_DP, ProdLo_DP};
    assign prodFinal = ResInv_SP ? -prodRaw : prodRaw;
    assign Res_DO    = HiSel_SP ? prodFinal[2*C_WIDTH-1:C_WIDTH] : prodFinal[C_WIDTH-1:0];
endmodule

// File: tb/tb_cv32e40p_alu_mul_serial.sv
// Directed bench for the serial multiplier: signed/unsigned products, latency,
// backpressure, asynchronous reset mid-operation and single-bit ECC fault correction.
module tb_cv32e40p_alu_mul_serial;
    logic        Clk_CI;
    logic        Rst_RI;
    logic [31:0] OpA_DI, OpB_DI;
    logic        OpASign_SI, OpBSign_SI, OpHigh_SI;
    logic        InVld_SI, OutRdy_SI;
    logic        OutVld_SO;
    logic [31:0] Res_DO;
    logic [4:0]  mem_err_o;

    int nTests = 0;
    int nFail  = 0;
    logic [38:0] cw;

    cv32e40p_alu_mul_serial #(.C_WIDTH(32), .C_LOG_WIDTH(6)) dut (
        .Clk_CI(Clk_CI), .Rst_RI(Rst_RI),
        .OpA_DI(OpA_DI), .OpB_DI(OpB_DI),
        .OpASign_SI(OpASign_SI), .OpBSign_SI(OpBSign_SI), .OpHigh_SI(OpHigh_SI),
        .InVld_SI(InVld_SI), .OutRdy_SI(OutRdy_SI),
        .OutVld_SO(OutVld_SO), .Res_DO(Res_DO), .mem_err_o(mem_err_o));

    initial Clk_CI = 1'b0;
    always #5 Clk_CI = ~Clk_CI;

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Waits (bounded) for OutVld_SO from just after the accepting edge; returns elapsed cycles
    task automatic waitDone(output int lat);
        lat = 0;
        while (!OutVld_SO && lat < 100) begin
            @(negedge Clk_CI);
            lat++;
        end
    endtask

    // Issue from IDLE at a negedge, check latency and result; leaves the unit in FINISH at a negedge
    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic aS, input logic bS, input logic hi, input logic [31:0] exp);
        int lat;
        OpA_DI = a; OpB_DI = b; OpASign_SI = aS; OpBSign_SI = bS; OpHigh_SI = hi;
        InVld_SI = 1'b1;
        #1 checkEq({tag, "_vld_on_accept"}, {31'b0, OutVld_SO}, 32'd0);
        @(posedge Clk_CI);
        #1 InVld_SI = 1'b0;
        waitDone(lat);
        checkEq({tag, "_latency"}, lat, 32'd33);
        checkEq({tag, "_res"}, Res_DO, exp);
    endtask

    task automatic drain();
        OutRdy_SI = 1'b1;
        @(posedge Clk_CI);
        #1 OutRdy_SI = 1'b0;
        @(negedge Clk_CI);
    endtask

    initial begin
        int lat;
        Rst_RI = 1'b1;
        OpA_DI = '0; OpB_DI = '0; OpASign_SI = 0; OpBSign_SI = 0; OpHigh_SI = 0;
        InVld_SI = 0; OutRdy_SI = 0;
        repeat (3) @(negedge Clk_CI);
        checkEq("rst_vld", {31'b0, OutVld_SO}, 32'd1);
        checkEq("rst_res", Res_DO, 32'd0);
        checkEq("rst_err", {27'b0, mem_err_o}, 32'd0);
        Rst_RI = 1'b0;
        @(negedge Clk_CI);
        checkEq("idle_vld", {31'b0, OutVld_SO}, 32'd1);

        // Basic products
        runOp("mul_7x6", 32'd7, 32'd6, 0, 0, 0, 32'd42);                       drain();
        runOp("mulh_m3x5", 32'hFFFFFFFD, 32'd5, 1, 0, 1, 32'hFFFFFFFF);        drain();
        runOp("mul_m3x5", 32'hFFFFFFFD, 32'd5, 1, 0, 0, 32'hFFFFFFF1);         drain();
        runOp("mulhu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 1, 32'hFFFFFFFE); drain();
        runOp("mulhsu_m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 1, 32'hFFFFFFFF); drain();
        runOp("mulh_min", 32'h80000000, 32'h80000000, 1, 1, 1, 32'h40000000);  drain();
        runOp("mul_min", 32'h80000000, 32'h80000000, 1, 1, 0, 32'h00000000);   drain();
        runOp("mulh_zero_inv", 32'd0, 32'hFFFFFFFB, 0, 1, 1, 32'd0);            drain();
        runOp("mul_zero_inv", 32'd0, 32'hFFFFFFFB, 0, 1, 0, 32'd0);             drain();
        runOp("mul_m7xm9", 32'hFFFFFFF9, 32'hFFFFFFF7, 1, 1, 0, 32'd63);         drain();

        // Backpressure: FINISH holds its result while requests are ignored
        runOp("bp", 32'd9, 32'd11, 0, 0, 0, 32'd99);
        for (int i = 0; i < 10; i++) begin
            InVld_SI = i[0];
            OpA_DI = 32'd100 + i; OpB_DI = 32'd3;
            #1;
            checkEq("bp_res_hold", Res_DO, 32'd99);
            checkEq("bp_vld_hold", {31'b0, OutVld_SO}, 32'd1);
            @(negedge Clk_CI);
        end
        InVld_SI = 1'b0;
        OutRdy_SI = 1'b1;
        @(posedge Clk_CI);
        #1 OutRdy_SI = 1'b0;
        // In IDLE a pending request drops OutVld_SO combinationally; in FINISH it would not
        InVld_SI = 1'b1;
        #1 checkEq("bp_back_to_idle", {31'b0, OutVld_SO}, 32'd0);
        InVld_SI = 1'b0;
        @(negedge Clk_CI);

        // Asynchronous reset in the middle of MULT
        OpA_DI = 32'd12345; OpB_DI = 32'd678; OpASign_SI = 0; OpBSign_SI = 0; OpHigh_SI = 0;
        InVld_SI = 1'b1;
        @(posedge Clk_CI);
        #1 InVld_SI = 1'b0;
        repeat (15) @(negedge Clk_CI);
        #2 Rst_RI = 1'b1;
        #1;
        checkEq("arst_vld", {31'b0, OutVld_SO}, 32'd1);
        checkEq("arst_res", Res_DO, 32'd0);
        @(negedge Clk_CI);
        Rst_RI = 1'b0;
        @(negedge Clk_CI);
        runOp("post_rst_3x4", 32'd3, 32'd4, 0, 0, 0, 32'd12); drain();

        // Single-bit fault in the product-low storage during MULT
        OpA_DI = 32'd1000; OpB_DI = 32'd1000; OpASign_SI = 0; OpBSign_SI = 0; OpHigh_SI = 0;
        InVld_SI = 1'b1;
        @(posedge Clk_CI);
        #1 InVld_SI = 1'b0;
        repeat (10) @(negedge Clk_CI);
        cw = dut.uProdLo.Data_DP;
        cw[7] = ~cw[7];
        force dut.uProdLo.Data_DP = cw;
        #1 checkEq("ecc_err_flag", {27'b0, mem_err_o}, 32'b01000);
        #1 release dut.uProdLo.Data_DP;
        waitDone(lat);
        checkEq("ecc_latency", lat, 32'd33 - 32'd10);
        checkEq("ecc_res", Res_DO, 32'd1000000);
        checkEq("ecc_err_clear", {27'b0, mem_err_o}, 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", nTests);
        $fatal(1);
    end
endmodule
